uart_rx_ext: RTL
================

# uart_rx_ext

Parametrised UART receiver for the peripheral UART subsystem: oversampled, majority-voted start/data/parity/stop reception with run-time selectable character length (5–8 bits), parity and stop-bit count. It adds an external oversampling tick, an input synchronizer, a valid/ready output holding register with overrun detection, and line-break detection. It sits between the pad-side `rxd` line and the UART register bank / RX FIFO.

## Interface
- `OVERSAMPLE`, 16, ticks per bit; legal 8..256.
- `SYNC_STAGES`, 2, flip-flop depth of the `rxd` synchronizer; legal 2..4.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset; one clock, all state cleared.
- `baud_tick`  in  1  one-cycle oversampling enable, OVERSAMPLE pulses per bit time.
- `rx_en`  in  1  receiver enable.
- `data_bits`  in  2  0: 5 bits, 1: 6, 2: 7, 3: 8.
- `parity_type`  in  2  0/1: none, 2: even, 3: odd.
- `nstop`  in  1  0: one stop bit, 1: two.
- `rxd`  in  1  serial input, asynchronous.
- `data_ready`  in  1  consumer accepts the held character.
- `data_out`  out  8  received character, right-aligned, upper unused bits 0.
- `data_valid`  out  1  holding register full.
- `parity_error`  out  1  parity mismatch, qualifies `data_out`.
- `frame_error`  out  1  a stop bit sampled 0, qualifies `data_out`.
- `break_detect`  out  1  held character was a line break.
- `overrun_error`  out  1  sticky: a completed frame was dropped.
- `busy`  out  1  FSM not in Idle.

## Operation
- `rxd` passes through SYNC_STAGES flops (reset value 1); all logic uses the synchronized `rxs`.
- Sample counter: counts `baud_tick` 0..OVERSAMPLE-1 and wraps; zeroed in Idle. Samples are taken on ticks at counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. Bit value is the 2-of-3 majority. Bit end is the tick at count OVERSAMPLE-1.
- FSM states: Idle, Start, Data, Parity, Stop1, Stop2, BreakWait.
  - Idle: `rxs`=0 and `rx_en` -> Start.
  - Start: at bit end, bit 0 -> Data with bit counter cleared; bit 1 -> Idle (glitch, no output).
  - Data: at each bit end, shift the bit in LSB first. After `data_bits`+5 bits -> Parity if `parity_type[1]`, else Stop1.
  - Parity: expected = XOR(data) ^ `parity_type[0]`; mismatch sets the internal parity flag. -> Stop1.
  - Stop1: bit 0 sets the frame flag. At bit end: break condition -> BreakWait; else `nstop` -> Stop2; else complete -> Idle.
  - Stop2: bit 0 sets the frame flag. At bit end: complete -> Idle.
  - BreakWait: complete with `break_detect`=1, `data_out`=0, `frame_error`=1. Stay until `rxs`=1, then -> Idle.
- Break condition: all data bits 0, parity bit 0 if present, and Stop1 sampled 0.
- Completion when `data_valid`=0: load `data_out` and the three flags, and set `data_valid`.
- Completion when `data_valid`=1 and no handshake that cycle: drop the new frame, keep the held data, set `overrun_error`.
- Handshake (`data_valid` & `data_ready`): clears `data_valid` and `overrun_error`. If a completion lands in the same cycle, load the new frame with no overrun.
- `rx_en` deasserted outside Idle: abort to Idle next clock. The holding register is unaffected and no output is produced.
- `data_bits`, `parity_type` and `nstop` are sampled on the Idle->Start transition and held for the frame.

## Timing
- Reset values: `data_out`=0; `data_valid`, `parity_error`, `frame_error`, `break_detect`, `overrun_error`, `busy`=0; FSM in Idle.
- Start-edge latency: SYNC_STAGES+1 clocks from the `rxd` fall to `busy`=1.
- `data_valid` rises one clock after the last stop bit's bit-end tick. For a break, it rises one clock after Stop1's bit-end tick, not after `rxd` returns high.
- Flags and `data_out` change only on a load and stay stable while `data_valid`=1.
- `baud_tick` at 0 freezes the counter; reception stretches with no other effect.

## Test plan
- 8N1, OVERSAMPLE=16, send 0xA5, `data_ready` tied 1 -> `data_valid` pulses one cycle with `data_out`=0xA5 and all flags 0.
- 7E2, send 0x35 with correct even parity -> `data_out`=0x35, `parity_error`=0. Repeat with the parity bit inverted -> `parity_error`=1, `data_valid`=1.
- 5O1, send 0x1F with Stop1 forced 0 -> `data_out`=0x1F, `frame_error`=1, `break_detect`=0.
- Hold `rxd`=0 for 20 bit times (8N1) -> one character with `data_out`=0, `break_detect`=1, `frame_error`=1. No further frame until `rxd` returns 1 and a new falling edge arrives.
- `data_ready`=0, send 0x11 then 0x22 -> `data_out` stays 0x11 and `overrun_error`=1. Asserting `data_ready` for one clock clears `data_valid` and `overrun_error`.
- Low glitch of 4 ticks on idle `rxd` -> returns to Idle with no `data_valid`. `reset_n` pulsed mid-Data -> all outputs 0 and `busy`=0 immediately.

Source files
------------

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: oversampled UART receiver with synchronizer, holding register, overrun and break detection
module uart_rx_ext #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       baud_tick,
    input  logic       rx_en,
    input  logic [1:0] data_bits,
    input  logic [1:0] parity_type,
    input  logic       nstop,
    input  logic       rxd,
    input  logic       data_ready,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       frame_error,
    output logic       break_detect,
    output logic       overrun_error,
    output logic       busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] SA   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SB   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] SC   = CW'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs;
    logic [CW-1:0]          cnt;
    logic [2:0]             samp;
    logic                   maj, bit_end, complete, is_break, brk_cond, hs;
    logic [7:0]             shreg;
    logic [2:0]             bcnt;
    logic                   pbit, perr, ferr;
    logic [1:0]             cfg_bits, cfg_par;
    logic                   cfg_nstop;

    assign rxs      = sync[SYNC_STAGES-1];
    assign maj      = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
    assign bit_end  = baud_tick && cnt == LAST;
    assign brk_cond = shreg == 8'h00 && !pbit && !maj;
    assign hs       = data_valid && data_ready;
    assign busy     = state != IDLE;

    // Bring the asynchronous line into the clock domain; idle line level is 1
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sync <= '1;
        else          sync <= {sync[SYNC_STAGES-2:0], rxd};
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next state and completion strobe; disabling the receiver aborts without output
    always_comb begin
        state_next = state;
        complete   = 1'b0;
        is_break   = 1'b0;
        case (state)
            IDLE:       if (!rxs && rx_en) state_next = START;
            START:      if (bit_end) state_next = maj ? IDLE : DATA;
            DATA:       if (bit_end && bcnt == {1'b0, cfg_bits} + 3'd4) state_next = cfg_par[1] ? PARITY : STOP1;
            PARITY:     if (bit_end) state_next = STOP1;
            STOP1: begin
                if (bit_end) begin
                    if (brk_cond) begin
                        state_next = BREAK_WAIT;
                        complete   = 1'b1;
                        is_break   = 1'b1;
                    end else if (cfg_nstop) begin
                        state_next = STOP2;
                    end else begin
                        state_next = IDLE;
                        complete   = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (bit_end) begin
                    state_next = IDLE;
                    complete   = 1'b1;
                end
            end
            BREAK_WAIT: if (rxs) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
        if (state != IDLE && !rx_en) begin
            state_next = IDLE;
            complete   = 1'b0;
            is_break   = 1'b0;
        end
    end

    // Oversample counter and the three mid-bit samples feeding the majority vote
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            samp <= 3'b111;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if (baud_tick) begin
            cnt <= cnt == LAST ? '0 : cnt + 1'b1;
            if (cnt == SA) samp[0] <= rxs;
            if (cnt == SB) samp[1] <= rxs;
            if (cnt == SC) samp[2] <= rxs;
        end
    end

    // Frame datapath: config capture at start, data shift, parity and stop checks
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg     <= '0;
            bcnt      <= '0;
            pbit      <= 1'b0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            cfg_bits  <= '0;
            cfg_par   <= '0;
            cfg_nstop <= 1'b0;
        end else if (state == IDLE && state_next == START) begin
            shreg     <= '0;
            bcnt      <= '0;
            pbit      <= 1'b0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            cfg_bits  <= data_bits;
            cfg_par   <= parity_type;
            cfg_nstop <= nstop;
        end else if (bit_end) begin
            if (state == DATA) begin
                shreg[bcnt] <= maj;
                bcnt        <= bcnt + 3'd1;
            end
            if (state == PARITY) begin
                pbit <= maj;
                perr <= maj != (^shreg ^ cfg_par[0]);
            end
            if ((state == STOP1 || state == STOP2) && !maj) ferr <= 1'b1;
        end
    end

    // Holding register: load on completion when free or being drained, otherwise flag overrun
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out      <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            frame_error   <= 1'b0;
            break_detect  <= 1'b0;
            overrun_error <= 1'b0;
        end else if (complete && (!data_valid || hs)) begin
            data_out      <= is_break ? 8'h00 : shreg;
            parity_error  <= perr;
            frame_error   <= ferr | !maj;
            break_detect  <= is_break;
            data_valid    <= 1'b1;
            overrun_error <= 1'b0;
        end else if (complete) begin
            overrun_error <= 1'b1;
        end else if (hs) begin
            data_valid    <= 1'b0;
            overrun_error <= 1'b0;
        end
    end
endmodule
